// File: rtl/m_unit_ctrl.sv
// Sequencer for the RV32M multiply/divide datapath: one op in flight, result over valid/ready.
// Latency: MUL* 2 cycles, DIV*/REM* 34 cycles, bypassed divide specials 1 cycle; holds result until out_ready.
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif

module m_unit_ctrl #(
    parameter bit SPECIAL_BYPASS = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     funct3,
    input  logic [31:0]                    rs1,
    input  logic [31:0]                    rs2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    result,
    output logic [31:0]                    alu_R,
    output logic [62:0]                    alu_D,
    output logic [31:0]                    alu_Z,
    output logic [32:0]                    alu_mult_a,
    output logic [32:0]                    alu_mult_b,
    output logic [`MUX_DIV_REM_LENGTH-1:0] alu_mux_div_rem,
    input  logic                           alu_sub_neg,
    input  logic [31:0]                    alu_sub_result,
    input  logic [31:0]                    alu_div_rem,
    input  logic [31:0]                    alu_div_rem_neg,
    input  logic [65:0]                    alu_product
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIN, S_DONE} state_t;

    state_t      state;
    logic [2:0]  op;
    logic        neg_q;
    logic        neg_r;
    logic [4:0]  cnt;
    logic [31:0] r_q;
    logic [62:0] d_q;
    logic [31:0] z_q;
    logic [32:0] mult_a;
    logic [32:0] mult_b;

    // funct3[0]=0 marks the signed DIV/REM encodings, funct3[1]=1 the remainder ones
    logic        div_signed;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] special_res;
    logic        unused_prod_bits;

    assign div_signed  = ~funct3[0];
    assign div_zero    = (rs2 == 32'd0);
    assign div_ovf     = div_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign abs_a       = (div_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
    assign abs_b       = (div_signed && rs2[31]) ? (32'd0 - rs2) : rs2;
    assign special_res = div_zero ? (funct3[1] ? rs1 : 32'hFFFF_FFFF)
                                  : (funct3[1] ? 32'd0 : 32'h8000_0000);
    assign unused_prod_bits = ^alu_product[65:64];

    assign alu_R           = r_q;
    assign alu_D           = d_q;
    assign alu_Z           = z_q;
    assign alu_mult_a      = mult_a;
    assign alu_mult_b      = mult_b;
    assign alu_mux_div_rem = `MUX_DIV_REM_LENGTH'(op[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            op        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            cnt       <= '0;
            r_q       <= '0;
            d_q       <= '0;
            z_q       <= '0;
            mult_a    <= '0;
            mult_b    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op       <= funct3;
                        in_ready <= 1'b0;
                        if (!funct3[2]) begin
                            mult_a <= {(funct3 == 3'd3) ? 1'b0 : rs1[31], rs1};
                            mult_b <= {funct3[1] ? 1'b0 : rs2[31], rs2};
                            state  <= S_MUL;
                        end else if (SPECIAL_BYPASS && (div_zero || div_ovf)) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            r_q   <= abs_a;
                            z_q   <= '0;
                            d_q   <= {abs_b, 31'b0};
                            cnt   <= 5'd31;
                            // a zero divisor must yield an all-ones quotient regardless of signs
                            neg_q <= div_signed && (rs1[31] ^ rs2[31]) && !div_zero;
                            neg_r <= div_signed && rs1[31];
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result    <= (op[1:0] == 2'd0) ? alu_product[31:0] : alu_product[63:32];
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DIV: begin
                    if (!alu_sub_neg) begin
                        r_q      <= alu_sub_result;
                        z_q[cnt] <= 1'b1;
                    end
                    d_q <= d_q >> 1;
                    if (cnt == 5'd0) begin
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_FIN: begin
                    result    <= (op[1] ? neg_r : neg_q) ? alu_div_rem_neg : alu_div_rem;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_unit_ctrl.sv
// Directed bench for m_unit_ctrl with a behavioural m_alu model supplying the datapath responses.
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif

module tb_m_unit_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] alu_R;
    logic [62:0] alu_D;
    logic [31:0] alu_Z;
    logic [32:0] alu_mult_a;
    logic [32:0] alu_mult_b;
    logic [`MUX_DIV_REM_LENGTH-1:0] alu_mux_div_rem;
    logic        alu_sub_neg;
    logic [31:0] alu_sub_result;
    logic [31:0] alu_div_rem;
    logic [31:0] alu_div_rem_neg;
    logic [65:0] alu_product;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m_unit_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .alu_R(alu_R), .alu_D(alu_D), .alu_Z(alu_Z),
        .alu_mult_a(alu_mult_a), .alu_mult_b(alu_mult_b), .alu_mux_div_rem(alu_mux_div_rem),
        .alu_sub_neg(alu_sub_neg), .alu_sub_result(alu_sub_result),
        .alu_div_rem(alu_div_rem), .alu_div_rem_neg(alu_div_rem_neg), .alu_product(alu_product)
    );

    // m_alu model
    logic [63:0]        diff;
    logic signed [65:0] pa, pb;
    always_comb begin
        diff            = {32'd0, alu_R} - {1'b0, alu_D};
        alu_sub_neg     = diff[63];
        alu_sub_result  = diff[31:0];
        alu_div_rem     = (alu_mux_div_rem != '0) ? alu_R : alu_Z;
        alu_div_rem_neg = 32'd0 - alu_div_rem;
        pa              = {{33{alu_mult_a[32]}}, alu_mult_a};
        pb              = {{33{alu_mult_b[32]}}, alu_mult_b};
        alu_product     = pa * pb;
    end

    // Issue one op from IDLE (#1 after an edge), return result and cycles from accept to out_valid.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; res = 32'hDEAD_BEEF;
        for (int n = 1; n < 100; n++) begin
            if (out_valid) begin
                lat = n; res = result;
                break;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b result=%h, want 1 0 0", in_ready, out_valid, result);
        end
        n_vec++;
        if (alu_R !== 32'd0 || alu_D !== 63'd0 || alu_Z !== 32'd0 || alu_mult_a !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_regs: R=%h D=%h Z=%h A=%h, want all 0", alu_R, alu_D, alu_Z, alu_mult_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat;
        do_op(f3, a, b, res, lat);
        n_vec++;
        if (res !== exp || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s: result=%h latency=%0d, want %h latency %0d", name, res, lat, exp, exp_lat);
        end
    endtask

    task automatic test_mul;
        test_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        test_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        test_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        test_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2);
    endtask

    task automatic test_div;
        test_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        test_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        test_op("divu", 3'd5, 32'd100,       32'd7, 32'd14,        34);
        test_op("remu", 3'd7, 32'd100,       32'd7, 32'd2,         34);
    endtask

    task automatic test_special;
        test_op("divu_by0", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        test_op("rem_by0",  3'd6, 32'd5,         32'd0,         32'd5,         1);
        test_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        test_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    endtask

    task automatic test_back_to_back;
        int lat = -1;
        in_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n < 100; n++) begin
            if (out_valid) begin lat = n; break; end
            @(posedge clk); #1;
        end
        n_vec++;
        if (lat != 34) begin
            n_fail++;
            $display("FAIL bp_latency: latency=%0d, want 34", lat);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid=%b result=%h in_ready=%b, want 1 0000000e 0",
                         k, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        test_op("bp_next_mul", 3'd0, 32'd6, 32'd5, 32'd30, 2);
    endtask

    task automatic test_flush;
        bit seen = 1'b0;
        in_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; funct3 = 3'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_no_valid: out_valid seen=%b, want 0", seen);
        end
        test_op("flush_next_mul", 3'd0, 32'd3, 32'd4, 32'd12, 2);
    endtask

    task automatic test_rst_mid_div;
        in_valid = 1'b1; funct3 = 3'd4; rs1 = 32'h0012_3456; rs2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: in_ready=%b out_valid=%b result=%h, want 1 0 0", in_ready, out_valid, result);
        end
        n_vec++;
        if (alu_R !== 32'd0 || alu_D !== 63'd0 || alu_Z !== 32'd0 || alu_mult_a !== 33'd0 || alu_mult_b !== 33'd0) begin
            n_fail++;
            $display("FAIL rst_mid_regs: R=%h D=%h Z=%h A=%h B=%h, want all 0", alu_R, alu_D, alu_Z, alu_mult_a, alu_mult_b);
        end
        test_op("rst_next_remu", 3'd7, 32'd1000, 32'd13, 32'd12, 34);
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_special;
        test_back_to_back;
        test_flush;
        test_rst_mid_div;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
